// File: rtl/mandelbrot_iter_unit.sv
// mandelbrot_iter_unit
// Sequential escape-time engine for a single pixel. A point is accepted in
// IDLE, iterated z <- z^2 + c one step per clock in signed 2.(WIDTH-2) fixed
// point, and the final iteration count is presented in DONE until taken.
// Mandelbrot mode starts from z = 0; Julia mode starts from the supplied z0.

module mandelbrot_iter_unit #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_julia,
    input  logic [WIDTH-1:0]     in_cr,
    input  logic [WIDTH-1:0]     in_ci,
    input  logic [WIDTH-1:0]     in_zr,
    input  logic [WIDTH-1:0]     in_zi,
    input  logic [CNT_WIDTH-1:0] in_max_iter,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] out_iter,
    output logic                 out_escaped
);

    // Extended width: products need 2*WIDTH bits, the difference/sum of two
    // products one more, and the added c one more; a little extra headroom
    // keeps every intermediate free of wrap-around.
    localparam int EW = 2 * WIDTH + 4;

    // 4.0 in the scale of (m1 + m2) >> (WIDTH-2), i.e. 2^WIDTH.
    localparam logic signed [EW-1:0] C_FOUR =
        {{(EW-WIDTH-1){1'b0}}, 1'b1, {WIDTH{1'b0}}};
    // Representable coordinate range [-2^(WIDTH-1), 2^(WIDTH-1)-1].
    localparam logic signed [EW-1:0] C_MAX =
        {{(EW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] C_MIN =
        {{(EW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [WIDTH-1:0]      r_zr;
    logic [WIDTH-1:0]      r_zi;
    logic [WIDTH-1:0]      r_cr;
    logic [WIDTH-1:0]      r_ci;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  r_max_iter;
    logic [CNT_WIDTH-1:0]  r_out_iter;
    logic                  r_out_escaped;

    logic signed [EW-1:0]  w_zr_x;
    logic signed [EW-1:0]  w_zi_x;
    logic signed [EW-1:0]  w_cr_x;
    logic signed [EW-1:0]  w_ci_x;
    logic signed [EW-1:0]  w_m1;
    logic signed [EW-1:0]  w_m2;
    logic signed [EW-1:0]  w_m3;
    logic signed [EW-1:0]  w_diff;
    logic signed [EW-1:0]  w_mag;
    logic signed [EW-1:0]  w_nzr_x;
    logic signed [EW-1:0]  w_nzi_x;
    logic                  w_size;
    logic                  w_ovf;
    logic                  w_escape;
    logic                  w_limit;

    // Sign-extend the registered operands into the wide datapath.
    assign w_zr_x = {{(EW-WIDTH){r_zr[WIDTH-1]}}, r_zr};
    assign w_zi_x = {{(EW-WIDTH){r_zi[WIDTH-1]}}, r_zi};
    assign w_cr_x = {{(EW-WIDTH){r_cr[WIDTH-1]}}, r_cr};
    assign w_ci_x = {{(EW-WIDTH){r_ci[WIDTH-1]}}, r_ci};

    assign w_m1    = w_zr_x * w_zr_x;
    assign w_m2    = w_zi_x * w_zi_x;
    assign w_m3    = w_zr_x * w_zi_x;
    assign w_diff  = w_m1 - w_m2;
    assign w_nzr_x = (w_diff >>> (WIDTH - 2)) + w_cr_x;
    // 2*zr*zi rescaled: the factor two folds into one less bit of shift.
    assign w_nzi_x = (w_m3 >>> (WIDTH - 3)) + w_ci_x;
    assign w_mag   = (w_m1 + w_m2) >>> (WIDTH - 2);

    assign w_size   = (w_mag > C_FOUR);
    assign w_ovf    = (w_nzr_x > C_MAX) || (w_nzr_x < C_MIN) ||
                      (w_nzi_x > C_MAX) || (w_nzi_x < C_MIN);
    assign w_escape = w_size || w_ovf;
    assign w_limit  = (r_count == r_max_iter);

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign out_iter    = r_out_iter;
    assign out_escaped = r_out_escaped;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection: accept, iterate until escape or limit, hand off.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next_state = S_ITER;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ITER: begin
                if (w_escape || w_limit) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_ITER;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture, z/count update and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zr          <= {WIDTH{1'b0}};
            r_zi          <= {WIDTH{1'b0}};
            r_cr          <= {WIDTH{1'b0}};
            r_ci          <= {WIDTH{1'b0}};
            r_count       <= {CNT_WIDTH{1'b0}};
            r_max_iter    <= {CNT_WIDTH{1'b0}};
            r_out_iter    <= {CNT_WIDTH{1'b0}};
            r_out_escaped <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cr       <= in_cr;
                        r_ci       <= in_ci;
                        r_max_iter <= in_max_iter;
                        r_count    <= {CNT_WIDTH{1'b0}};
                        r_zr       <= in_julia ? in_zr : {WIDTH{1'b0}};
                        r_zi       <= in_julia ? in_zi : {WIDTH{1'b0}};
                    end
                end
                S_ITER: begin
                    // Escape is tested before the limit, so the z reached at
                    // count == N is still checked for escape.
                    if (w_escape) begin
                        r_out_iter    <= r_count;
                        r_out_escaped <= 1'b1;
                    end else if (w_limit) begin
                        r_out_iter    <= r_max_iter;
                        r_out_escaped <= 1'b0;
                    end else begin
                        r_zr    <= w_nzr_x[WIDTH-1:0];
                        r_zi    <= w_nzi_x[WIDTH-1:0];
                        r_count <= r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    r_out_iter    <= r_out_iter;
                    r_out_escaped <= r_out_escaped;
                end
                default: begin
                    r_count <= {CNT_WIDTH{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: doc/mandelbrot_iter_unit.md
# mandelbrot_iter_unit

Sequential escape-time engine for one pixel. It accepts a point, iterates z ← z² + c in signed fixed point, one iteration per clock, until escape or an iteration limit. It returns the iteration count over a valid/ready handshake. It generalises the single-step combinational Mandelbrot datapath with a programmable iteration limit, a Julia mode and output backpressure, and sits between the pixel coordinate generator and the colour mapper.

## Interface
Parameters:
- WIDTH, 8: coordinate width; all coordinates are signed fixed point 2.(WIDTH-2), so 1.0 = 2^(WIDTH-2). Legal range is WIDTH ≥ 6.
- CNT_WIDTH, 8: width of the iteration limit and the iteration count.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input point valid.
- in_ready  out  1  unit can accept a point (high only in IDLE).
- in_julia  in  1  0 = Mandelbrot mode, 1 = Julia mode.
- in_cr, in_ci  in  WIDTH  constant c.
- in_zr, in_zi  in  WIDTH  start value z0; used only when in_julia=1.
- in_max_iter  in  CNT_WIDTH  iteration limit N.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_iter  out  CNT_WIDTH  final iteration count.
- out_escaped  out  1  1 = point escaped; 0 = limit reached.

## Operation
- States:
  - IDLE: in_ready=1.
  - ITER: iterating.
  - DONE: out_valid=1.
- Accept: when in_valid && in_ready, register the inputs below and go to ITER.
  - c, N.
  - z = 0 in Mandelbrot mode, or z = (in_zr, in_zi) in Julia mode.
  - count = 0.
- Datapath, evaluated each ITER cycle on the registered z and c:
  - Full products: m1=zr², m2=zi², m3=zr·zi, each 2·WIDTH bits.
  - nzr = ((m1 − m2) >>> (WIDTH−2)) + cr.
  - nzi = (m3 >>> (WIDTH−3)) + ci.
  - `>>>` is an arithmetic shift, which floors the result. All intermediates carry enough bits that no internal wrap occurs.
  - overflow = nzr or nzi lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - size = ((m1 + m2) >> (WIDTH−2)) > 4·2^(WIDTH−2), i.e. |z|² > 4.0, strictly greater.
- ITER decision, in priority order each cycle:
  1. size || overflow → DONE, out_escaped=1, out_iter=count.
  2. Otherwise count == N → DONE, out_escaped=0, out_iter=N.
  3. Otherwise z ← (nzr, nzi), count ← count+1.
- DONE: out_iter and out_escaped stay stable while out_valid=1 && out_ready=0. On out_ready=1 go to IDLE.
- The escape check precedes the limit check. With N=0 the result comes after one ITER cycle: out_iter=0, and out_escaped reflects only the z0 check.
- count never wraps, because it stops at N ≤ 2^CNT_WIDTH−1.
- Inputs are ignored outside the accept cycle. Changing in_* during ITER or DONE has no effect.

## Timing
- Reset: state=IDLE, in_ready=1, out_valid=0, out_iter=0, out_escaped=0. Internal z, c and count are cleared to 0.
- Reset has priority over every transition, including mid-ITER and in DONE with out_valid pending. A pending result is discarded, not presented.
- The accept edge is cycle 0. The ITER decision for count=k happens at edge k+1.
- out_valid rises after edge F+1, where F = final out_iter. Latency from accept to out_valid is therefore F+1 cycles.
- Result transfer happens on an edge with out_valid && out_ready. in_ready rises in the following cycle.
- Back-to-back operation: minimum issue interval is F+3 cycles (accept, F+1 ITER cycles, DONE ≥1 cycle); there is no overlap.
- in_ready and out_valid are never high in the same cycle.

## Test plan
- Mandelbrot, WIDTH=8, c=(0,0), N=20, out_ready=1 → out_valid 21 cycles after accept; out_iter=20, out_escaped=0.
- Mandelbrot, c=(32,0) (0.5), N=50 → z sequence 0,32,48,68,104; overflow at count=4 → out_iter=4, out_escaped=1, out_valid 5 cycles after accept.
- Julia mode, z0=(96,96) (1.5+1.5i), c=(0,0), N=10 → |z0|²=4.5>4 → out_iter=0, out_escaped=1. Mandelbrot mode with the same inputs → out_iter=10, out_escaped=0.
- Backpressure: hold out_ready=0 for 7 cycles in DONE while changing all in_* → out_iter and out_escaped stable, in_ready=0, no second accept; release → transfer, then in_ready=1 next cycle.
- Reset mid-ITER: assert rst at count=3 of a c=(0,0), N=20 run → next cycle IDLE, in_ready=1, out_valid=0, out_iter=0; a fresh accept then completes normally.
- N=0 with c=(0,0) → out_iter=0, out_escaped=0 one cycle after accept. Boundary c=(−128,0) (−2.0), N=5 → |z|²=4.0 is not an escape; the next z of 2.0 overflows → out_iter=1, out_escaped=1.
